// File: rtl/port_slice_pkg.sv
// Shared types and the bus-slice transform used by the port slice arbiter.
// The transform keeps word[7:5], word[3] and word[2]; the other bits are dropped.
package port_slice_pkg;

  localparam int unsigned SLICE_IN_W  = 8;
  localparam int unsigned SLICE_OUT_W = 5;

  typedef enum logic [0:0] {
    StUnlocked,
    StLocked
  } lock_state_e;

  typedef struct packed {
    logic [SLICE_OUT_W-1:0] out_bus;
    logic                   out_single;
  } slice_result_t;

  function automatic slice_result_t slice_xform(input logic [SLICE_IN_W-1:0] word,
                                                input logic                  single);
    slice_result_t res;
    logic          unused_bits;
    unused_bits    = ^{word[4], word[1:0]};
    res.out_bus    = {word[7:5], word[3], ~single};
    res.out_single = word[2];
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority rotate.
// Searches ptr+1, ptr+2, ... modulo NUM_REQ and returns a one-hot grant (or zero).
module rr_arbiter #(
  parameter int unsigned  NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((32'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/port_slice_arbiter.sv
// Round-robin arbiter sharing one bus-slice datapath among NUM_REQ requesters,
// with burst locking and a one-entry valid/ready output register.
module port_slice_arbiter
  import port_slice_pkg::*;
#(
  parameter int unsigned  NUM_REQ   = 4,
  parameter int unsigned  MAX_BURST = 4,
  localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*SLICE_IN_W-1:0]    req_bus,
  input  logic [NUM_REQ-1:0]               req_single,
  input  logic [NUM_REQ-1:0]               req_lock,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SLICE_OUT_W-1:0]           out_bus,
  output logic                             out_single,
  output logic [ID_W-1:0]                  out_id,
  output logic                             busy
);

  localparam logic [3:0] BurstMax = 4'(MAX_BURST);

  lock_state_e            lock_state_q, lock_state_d;
  logic [ID_W-1:0]        owner_q, owner_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [3:0]             burst_cnt_q, burst_cnt_d;
  logic                   idle_q, idle_d;
  logic                   out_valid_q, out_valid_d;
  logic [SLICE_OUT_W-1:0] out_bus_q, out_bus_d;
  logic                   out_single_q, out_single_d;
  logic [ID_W-1:0]        out_id_q, out_id_d;

  logic                   can_accept;
  logic                   xfer;
  logic [NUM_REQ-1:0]     owner_mask;
  logic [NUM_REQ-1:0]     arb_req;
  logic [NUM_REQ-1:0]     grant;
  logic [ID_W-1:0]        gnt_idx;
  logic [SLICE_IN_W-1:0]  gnt_word;
  slice_result_t          slice_res;

  // While locked only the owner may compete; an idle owner blocks everyone.
  always_comb begin
    owner_mask          = '0;
    owner_mask[owner_q] = 1'b1;
    arb_req = (lock_state_q == StLocked) ? (req_valid & owner_mask) : req_valid;
  end

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .req  (arb_req),
    .ptr  (rr_ptr_q),
    .grant(grant)
  );

  always_comb begin
    can_accept = !out_valid_q || out_ready;
    req_ready  = (rst_n && can_accept) ? grant : '0;
    xfer       = |req_ready;
    gnt_idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gnt_idx = ID_W'(i);
    end
    gnt_word  = req_bus[gnt_idx*SLICE_IN_W +: SLICE_IN_W];
    slice_res = slice_xform(gnt_word, req_single[gnt_idx]);
  end

  // Lock FSM: burst limit, lock drop and a two-cycle starvation guard all release.
  always_comb begin
    lock_state_d = lock_state_q;
    owner_d      = owner_q;
    burst_cnt_d  = burst_cnt_q;
    idle_d       = 1'b0;
    unique case (lock_state_q)
      StUnlocked: begin
        if (xfer && req_lock[gnt_idx] && (MAX_BURST > 1)) begin
          lock_state_d = StLocked;
          owner_d      = gnt_idx;
          burst_cnt_d  = 4'd1;
        end
      end
      StLocked: begin
        if (xfer) burst_cnt_d = burst_cnt_q + 4'd1;
        idle_d = !req_valid[owner_q];
        if ((xfer && ((burst_cnt_q + 4'd1) == BurstMax)) || !req_lock[owner_q] ||
            (idle_q && !req_valid[owner_q])) begin
          lock_state_d = StUnlocked;
          burst_cnt_d  = '0;
          idle_d       = 1'b0;
        end
      end
      default: lock_state_d = StUnlocked;
    endcase
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_bus_d    = out_bus_q;
    out_single_d = out_single_q;
    out_id_d     = out_id_q;
    rr_ptr_d     = rr_ptr_q;
    if (xfer) begin
      out_valid_d  = 1'b1;
      out_bus_d    = slice_res.out_bus;
      out_single_d = slice_res.out_single;
      out_id_d     = gnt_idx;
      rr_ptr_d     = gnt_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_state_q <= StUnlocked;
      owner_q      <= '0;
      burst_cnt_q  <= '0;
      idle_q       <= 1'b0;
      rr_ptr_q     <= ID_W'(NUM_REQ - 1);
      out_valid_q  <= 1'b0;
      out_bus_q    <= '0;
      out_single_q <= 1'b0;
      out_id_q     <= '0;
    end else begin
      lock_state_q <= lock_state_d;
      owner_q      <= owner_d;
      burst_cnt_q  <= burst_cnt_d;
      idle_q       <= idle_d;
      rr_ptr_q     <= rr_ptr_d;
      out_valid_q  <= out_valid_d;
      out_bus_q    <= out_bus_d;
      out_single_q <= out_single_d;
      out_id_q     <= out_id_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_bus    = out_bus_q;
  assign out_single = out_single_q;
  assign out_id     = out_id_q;
  assign busy       = out_valid_q || (|req_valid);

endmodule

// File: tb/tb_port_slice_arbiter.sv
// Self-checking bench for port_slice_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural model of the arbitration and lock rules.
module tb_port_slice_arbiter;

  localparam int NR = 4;
  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_single = '0;
  logic [3:0]  req_lock = '0;
  logic [31:0] req_bus = '0;
  logic        out_ready = 1'b0;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [4:0]  out_bus;
  logic        out_single;
  logic [1:0]  out_id;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  port_slice_arbiter #(
    .NUM_REQ  (NR),
    .MAX_BURST(MB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_bus   (req_bus),
    .req_single(req_single),
    .req_lock  (req_lock),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bus   (out_bus),
    .out_single(out_single),
    .out_id    (out_id),
    .busy      (busy)
  );

  // Behavioural model state
  bit         m_out_valid = 1'b0;
  logic [4:0] m_out_bus = '0;
  bit         m_out_single = 1'b0;
  int         m_out_id = 0;
  int         m_rr = NR - 1;
  bit         m_locked = 1'b0;
  int         m_owner = 0;
  int         m_cnt = 0;
  int         m_idle = 0;

  function automatic int m_grant();
    if (!rst_n) return -1;
    if (m_locked) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 1; k <= NR; k++) begin
      int j = (m_rr + k) % NR;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_ready();
    int g = m_grant();
    if (g < 0 || !(!m_out_valid || out_ready)) return 4'd0;
    return 4'(1 << g);
  endfunction

  function automatic logic [4:0] m_slice(input logic [7:0] w, input logic s);
    int v = int'(w);
    return 5'((v / 32) * 4 + ((v / 8) % 2) * 2 + (s ? 0 : 1));
  endfunction

  always @(posedge clk) begin : model
    int g;
    bit xf;
    int cnt;
    bit unlock;
    g  = m_grant();
    xf = (g >= 0) && (!m_out_valid || out_ready);
    if (!rst_n) begin
      m_out_valid  <= 1'b0;
      m_out_bus    <= '0;
      m_out_single <= 1'b0;
      m_out_id     <= 0;
      m_rr         <= NR - 1;
      m_locked     <= 1'b0;
      m_cnt        <= 0;
      m_idle       <= 0;
    end else begin
      if (m_locked) begin
        cnt    = m_cnt + (xf ? 1 : 0);
        unlock = (xf && cnt == MB) || !req_lock[m_owner] || (!req_valid[m_owner] && m_idle == 1);
        if (unlock) begin
          m_locked <= 1'b0;
          m_cnt    <= 0;
          m_idle   <= 0;
        end else begin
          m_cnt  <= cnt;
          m_idle <= req_valid[m_owner] ? 0 : m_idle + 1;
        end
      end else if (xf && req_lock[g] && MB > 1) begin
        m_locked <= 1'b1;
        m_owner  <= g;
        m_cnt    <= 1;
        m_idle   <= 0;
      end
      if (xf) begin
        m_out_valid  <= 1'b1;
        m_out_id     <= g;
        m_out_bus    <= m_slice(req_bus[g*8 +: 8], req_single[g]);
        m_out_single <= ((int'(req_bus[g*8 +: 8]) / 4) % 2) == 1;
        m_rr         <= g;
      end else if (out_ready) begin
        m_out_valid <= 1'b0;
      end
    end
  end

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; req_lock = '0; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'hF; req_bus = $urandom; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (out_bus !== 5'd0) begin errors++; $display("FAIL reset_out_bus: got %0h expected 0", out_bus); end
    checks++; if (out_single !== 1'b0) begin errors++; $display("FAIL reset_out_single: got %0b expected 0", out_single); end
    checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL reset_out_id: got %0d expected 0", out_id); end
    checks++; if (req_ready !== 4'd0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %0b expected 1", busy); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_single();
    @(negedge clk);
    rst_n = 1'b1; req_valid = 4'b0100; req_bus = $urandom; req_bus[23:16] = 8'hA4;
    req_single = 4'($urandom); req_single[2] = 1'b0; req_lock = '0; out_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b expected 1", out_valid); end
    checks++; if (out_id !== 2'd2) begin errors++; $display("FAIL single_id: got %0d expected 2", out_id); end
    checks++; if (out_bus !== 5'b10101) begin errors++; $display("FAIL single_bus: got %b expected 10101", out_bus); end
    checks++; if (out_single !== 1'b1) begin errors++; $display("FAIL single_single: got %0b expected 1", out_single); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %0b expected 1", busy); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %0b expected 0", out_valid); end
  endtask

  task automatic test_fairness();
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      if (i != 0) @(negedge clk);
      req_valid = 4'hF; req_bus = $urandom; req_single = 4'($urandom); req_lock = '0; out_ready = 1'b1;
      #1;
      checks++; if (req_ready !== m_ready()) begin errors++; $display("FAIL fair_ready[%0d]: got %b expected %b", i, req_ready, m_ready()); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fair_valid[%0d]: got %0b expected 1", i, out_valid); end
      checks++; if (out_id !== 2'(i % 4)) begin errors++; $display("FAIL fair_id[%0d]: got %0d expected %0d", i, out_id, i % 4); end
      checks++; if ({out_bus, out_single} !== {m_out_bus, m_out_single}) begin errors++;
        $display("FAIL fair_data[%0d]: got %h/%b expected %h/%b", i, out_bus, out_single, m_out_bus, m_out_single); end
    end
  endtask

  task automatic test_backpressure();
    int         snap_id;
    logic [4:0] snap_bus;
    bit         snap_single;
    snap_id = m_out_id; snap_bus = m_out_bus; snap_single = m_out_single;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b0; req_valid = 4'hF; req_bus = $urandom; req_single = 4'($urandom);
      #1;
      checks++; if (req_ready !== 4'd0) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0000", i, req_ready); end
      @(posedge clk); #1;
      checks++; if ({out_valid, out_id, out_bus, out_single} !== {1'b1, 2'(snap_id), snap_bus, snap_single}) begin
        errors++; $display("FAIL bp_hold[%0d]: got %0b/%0d/%h/%b expected 1/%0d/%h/%b", i, out_valid, out_id,
                           out_bus, out_single, snap_id, snap_bus, snap_single); end
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      out_ready = 1'b1; req_bus = $urandom; req_single = 4'($urandom);
      @(posedge clk); #1;
      checks++; if (out_id !== 2'((snap_id + 1 + k) % 4) || out_valid !== 1'b1) begin errors++;
        $display("FAIL bp_resume[%0d]: got id %0d valid %0b expected id %0d valid 1", k, out_id, out_valid,
                 (snap_id + 1 + k) % 4); end
      checks++; if (out_bus !== m_out_bus) begin errors++; $display("FAIL bp_bus[%0d]: got %h expected %h", k, out_bus, m_out_bus); end
    end
  endtask

  task automatic test_burst_lock();
    int exp_ids[9] = '{0, 1, 1, 1, 1, 2, 3, 0, 1};
    reset_dut();
    for (int i = 0; i < 9; i++) begin
      if (i != 0) @(negedge clk);
      req_valid = 4'hF; req_lock = 4'b0010; out_ready = 1'b1; req_bus = $urandom; req_single = 4'($urandom);
      #1;
      checks++; if (req_ready !== m_ready()) begin errors++; $display("FAIL burst_ready[%0d]: got %b expected %b", i, req_ready, m_ready()); end
      @(posedge clk); #1;
      checks++; if (out_id !== 2'(exp_ids[i])) begin errors++; $display("FAIL burst_id[%0d]: got %0d expected %0d", i, out_id, exp_ids[i]); end
    end
  endtask

  task automatic test_starvation();
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      req_valid = 4'hF; req_lock = 4'b1000; out_ready = 1'b1; req_bus = $urandom;
      @(posedge clk); #1;
      checks++; if (out_id !== 2'(i)) begin errors++; $display("FAIL starve_pre_id[%0d]: got %0d expected %0d", i, out_id, i); end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req_valid = 4'b0111;
      #1;
      checks++; if (req_ready !== 4'd0) begin errors++; $display("FAIL starve_wait[%0d]: got %b expected 0000", i, req_ready); end
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL starve_release: got %b expected 0001", req_ready); end
    @(posedge clk); #1;
    checks++; if (out_id !== 2'd0 || out_valid !== 1'b1) begin errors++;
      $display("FAIL starve_id: got id %0d valid %0b expected id 0 valid 1", out_id, out_valid); end
  endtask

  task automatic test_lock_release();
    int exp_ids[5]   = '{0, 1, 1, 1, 2};
    int lock_pat[5]  = '{2, 2, 2, 0, 0};
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      req_valid = 4'hF; req_lock = 4'(lock_pat[i]); out_ready = 1'b1; req_bus = $urandom;
      @(posedge clk); #1;
      checks++; if (out_id !== 2'(exp_ids[i])) begin errors++; $display("FAIL release_id[%0d]: got %0d expected %0d", i, out_id, exp_ids[i]); end
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    req_valid = 4'hF; req_lock = 4'b0010; out_ready = 1'b1; req_bus = $urandom;
    repeat (2) @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if ({out_valid, out_id, out_bus, out_single} !== 9'd0) begin errors++;
      $display("FAIL midreset_out: got %0b/%0d/%h/%b expected all 0", out_valid, out_id, out_bus, out_single); end
    checks++; if (req_ready !== 4'd0) begin errors++; $display("FAIL midreset_ready: got %b expected 0000", req_ready); end
    @(negedge clk);
    rst_n = 1'b1; req_valid = 4'hF; req_lock = '0; out_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL midreset_first_grant: got %b expected 0001", req_ready); end
    @(posedge clk); #1;
    checks++; if (out_id !== 2'd0 || out_valid !== 1'b1) begin errors++;
      $display("FAIL midreset_id: got id %0d valid %0b expected id 0 valid 1", out_id, out_valid); end
  endtask

  task automatic test_random();
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      if (i != 0) @(negedge clk);
      rst_n      = ($urandom_range(0, 63) != 0);
      req_valid  = 4'($urandom);
      req_bus    = $urandom;
      req_single = 4'($urandom);
      req_lock   = 4'($urandom) & 4'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      #1;
      checks++; if (req_ready !== m_ready()) begin errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, req_ready, m_ready()); end
      checks++; if (busy !== (m_out_valid || req_valid != 4'd0)) begin errors++;
        $display("FAIL rand_busy[%0d]: got %0b expected %0b", i, busy, m_out_valid || req_valid != 4'd0); end
      @(posedge clk); #1;
      checks++; if (out_valid !== m_out_valid) begin errors++; $display("FAIL rand_valid[%0d]: got %0b expected %0b", i, out_valid, m_out_valid); end
      if (m_out_valid) begin
        checks++; if ({out_id, out_bus, out_single} !== {2'(m_out_id), m_out_bus, m_out_single}) begin errors++;
          $display("FAIL rand_data[%0d]: got %0d/%h/%b expected %0d/%h/%b", i, out_id, out_bus, out_single,
                   m_out_id, m_out_bus, m_out_single); end
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_burst_lock();
    test_starvation();
    test_lock_release();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
